mesh_pe_ni: RTL
===============

Name: mesh_pe_ni

Overview:
- Clocked PE-side network interface for the 2x3 router mesh; one instance per tile, attached to that tile's PE injection/ejection channel pair.
- TX path packetizes a PE request (destination node + payload) into a mesh packet carrying X/Y hop fields and drives it onto the router's input channel with a 4-phase bundled-data handshake.
- RX path accepts packets from the router's output channel with the same handshake, buffers one packet and presents its payload to the PE with valid/ready.

Parameters:
- WIDTH, 16, packet width; the mesh is instantiated with the same WIDTH.
- X_HOP_LOC, 2, MSB of x-hop count field; bit 0 = x direction.
- Y_HOP_LOC, 5, MSB of y-hop count field; bit X_HOP_LOC+1 = y direction.
- ROWS, 2, mesh rows. COLS, 3, mesh columns.
- NODE_NUM, 0, own node id = COLS*row+col.
- NODE_W, 3, width of node id (>= clog2(ROWS*COLS)).
- PL_W, WIDTH-Y_HOP_LOC-1, payload width (10).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- pe_tx_valid  in  1  PE send request.
- pe_tx_ready  out  1  NI can accept a send.
- pe_tx_dest  in  NODE_W  destination node id.
- pe_tx_payload  in  PL_W  payload.
- pe_tx_err  out  1  one-cycle pulse: destination rejected.
- net_tx_req  out  1  4-phase request to router PE input.
- net_tx_data  out  WIDTH  bundled packet.
- net_tx_ack  in  1  asynchronous ack from router.
- net_rx_req  in  1  asynchronous request from router PE output.
- net_rx_data  in  WIDTH  bundled packet from router.
- net_rx_ack  out  1  4-phase ack to router.
- pe_rx_valid  out  1  received payload available.
- pe_rx_ready  in  1  PE consumes payload.
- pe_rx_payload  out  PL_W  received payload.
- pe_rx_hop_err  out  1  sticky hop-field error (see Optional Feature).

Behaviour:
- Packet format: [0] xdir (1 = increasing column), [X_HOP_LOC:1] x hops, [X_HOP_LOC+1] ydir (1 = increasing row), [Y_HOP_LOC:X_HOP_LOC+2] y hops, [WIDTH-1:Y_HOP_LOC+1] payload.
- Reset values: all outputs 0, except pe_tx_ready = 1 after reset release; FSMs return to idle; synchronizers cleared. Reset mid-handshake drops req/ack immediately; the router side is reset together with the NI.
- net_tx_ack and net_rx_req each pass through a 2-flop synchronizer; every FSM decision uses the synchronized value.
- TX FSM T_IDLE/T_REQ/T_REL:
  - T_IDLE: pe_tx_ready = 1. On valid & ready:
    - dest >= ROWS*COLS: pe_tx_err pulses next cycle; no packet; stay in T_IDLE.
    - Otherwise: register dcol = dest%COLS and drow = dest/COLS; xhops = |dcol-mycol|; xdir = dcol>mycol; y fields likewise; go to T_REQ.
  - T_REQ: net_tx_req = 1 starting the cycle after accept; net_tx_data is stable from that cycle until T_IDLE. Wait for ack_s = 1, then go to T_REL.
  - T_REL: req = 0; wait for ack_s = 0, then go to T_IDLE.
  - pe_tx_ready = 0 in T_REQ and T_REL.
  - Self-destination is sent with zero hop fields.
- RX FSM R_IDLE/R_ACK plus a one-entry buffer:
  - R_IDLE: if req_s = 1 and the buffer is empty, or is being popped in the same cycle, capture net_rx_data, set buffer full, assert net_rx_ack next cycle, go to R_ACK.
  - R_ACK: hold ack = 1 until req_s = 0, then drop ack and go to R_IDLE.
  - pe_rx_valid = buffer full. Pop on valid & ready.
  - Pop and capture in the same cycle: the new packet replaces the old one; valid stays 1.
  - Back-pressure: a req arriving while the buffer is full and not being popped is held off; ack stays 0.
- Minimum TX cycle is about 6 clocks per packet (2 synchronizer stages per edge).

Optional Feature:
- Macro NI_HOP_CHECK_EN.
- Defined: on capture, if x-hop or y-hop field != 0, pe_rx_hop_err sets and stays set until rst. The payload is still delivered.
- Undefined: pe_rx_hop_err is tied to 0 and no check logic is built.

Decomposition:
- Package mesh_ni_pkg holds:
  - tx_state_t and rx_state_t enums.
  - Field-position localparams derived from X_HOP_LOC/Y_HOP_LOC.
  - Function build_header(src, dst, COLS).
- Sub-module ni_sync2: 2-flop synchronizer with async active-high clear, instantiated twice.

Test Plan:
- NODE_NUM=0, dest=5, payload=0x2A5 -> net_tx_data=0xA95D, req high 1 cycle after accept; bench ack returns req->0 then pe_tx_ready=1.
- NODE_NUM=5, dest=0, payload=0x001 -> data=0x0054 (xdir=0, xhops=2, ydir=0, yhops=1).
- dest=6 -> pe_tx_err one-cycle pulse, net_tx_req stays 0, ready stays 1.
- Router sends 0x7FC0 with pe_rx_ready=0 -> pe_rx_valid=1, payload=0x1FF, ack completes; a second req is not acked until pop; after pe_rx_ready=1 the second packet is delivered.
- NI_HOP_CHECK_EN defined, incoming 0x0042 -> pe_rx_hop_err=1 and sticky; undefined -> 0.
- rst asserted while in T_REQ -> net_tx_req=0 immediately; after release pe_tx_ready=1 and a new send completes normally.

Source files
------------

// File: rtl/mesh_pe_ni_pkg.sv
// Shared NI definitions: header field positions, FSM state encodings, header builder.
package mesh_ni_pkg;

  localparam int XHOP_MSB  = 2;
  localparam int YHOP_MSB  = 5;

  localparam int XDIR_BIT  = 0;
  localparam int XH_LSB    = 1;
  localparam int XH_MSB    = XHOP_MSB;
  localparam int YDIR_BIT  = XHOP_MSB + 1;
  localparam int YH_LSB    = XHOP_MSB + 2;
  localparam int YH_MSB    = YHOP_MSB;
  localparam int HDR_W     = YHOP_MSB + 1;
  localparam int XH_W      = XH_MSB - XH_LSB + 1;
  localparam int YH_W      = YH_MSB - YH_LSB + 1;

  typedef logic [1:0] tx_state_t;
  localparam tx_state_t T_IDLE = 2'd0;
  localparam tx_state_t T_REQ  = 2'd1;
  localparam tx_state_t T_REL  = 2'd2;

  typedef logic [0:0] rx_state_t;
  localparam rx_state_t R_IDLE = 1'b0;
  localparam rx_state_t R_ACK  = 1'b1;

  // Direction bit set means the destination lies at a larger column/row index.
  function automatic logic [HDR_W-1:0] build_header(input int src, input int dst, input int cols);
    int sc, sr, dc, dr;
    logic [HDR_W-1:0] h;
    sc = src % cols;
    sr = src / cols;
    dc = dst % cols;
    dr = dst / cols;
    h = '0;
    h[XDIR_BIT]        = (dc > sc);
    h[XH_MSB:XH_LSB]   = XH_W'((dc > sc) ? (dc - sc) : (sc - dc));
    h[YDIR_BIT]        = (dr > sr);
    h[YH_MSB:YH_LSB]   = YH_W'((dr > sr) ? (dr - sr) : (sr - dr));
    return h;
  endfunction

endpackage

// File: rtl/mesh_pe_ni_if.sv
// PE and router channel bundle for one NI; slave = the NI, master = PE/router side.
interface mesh_pe_ni_if #(
  parameter int WIDTH  = 16,
  parameter int NODE_W = 3,
  parameter int PL_W   = 10
);
  logic              pe_tx_valid;
  logic              pe_tx_ready;
  logic [NODE_W-1:0] pe_tx_dest;
  logic [PL_W-1:0]   pe_tx_payload;
  logic              pe_tx_err;
  logic              net_tx_req;
  logic [WIDTH-1:0]  net_tx_data;
  logic              net_tx_ack;
  logic              net_rx_req;
  logic [WIDTH-1:0]  net_rx_data;
  logic              net_rx_ack;
  logic              pe_rx_valid;
  logic              pe_rx_ready;
  logic [PL_W-1:0]   pe_rx_payload;
  logic              pe_rx_hop_err;

  modport slave (
    input  pe_tx_valid, pe_tx_dest, pe_tx_payload, net_tx_ack,
           net_rx_req, net_rx_data, pe_rx_ready,
    output pe_tx_ready, pe_tx_err, net_tx_req, net_tx_data,
           net_rx_ack, pe_rx_valid, pe_rx_payload, pe_rx_hop_err
  );

  modport master (
    output pe_tx_valid, pe_tx_dest, pe_tx_payload, net_tx_ack,
           net_rx_req, net_rx_data, pe_rx_ready,
    input  pe_tx_ready, pe_tx_err, net_tx_req, net_tx_data,
           net_rx_ack, pe_rx_valid, pe_rx_payload, pe_rx_hop_err
  );
endinterface

// File: rtl/mesh_pe_ni_sync2.sv
// Two-flop synchronizer for an asynchronous handshake line, cleared by reset.
module ni_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/mesh_pe_ni.sv
// PE-side mesh network interface: TX packetizer + 4-phase sender, RX 4-phase receiver + 1-entry buffer.
// Optional hop-field check on received packets enabled by NI_HOP_CHECK_EN.
module mesh_pe_ni
  import mesh_ni_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int X_HOP_LOC = XHOP_MSB,
  parameter int Y_HOP_LOC = YHOP_MSB,
  parameter int ROWS      = 2,
  parameter int COLS      = 3,
  parameter int NODE_NUM  = 0,
  parameter int NODE_W    = 3,
  parameter int PL_W      = WIDTH - Y_HOP_LOC - 1
) (
  input  logic          clk,
  input  logic          rst,
  mesh_pe_ni_if.slave   bus
);

  logic ack_s;
  logic req_s;

  ni_sync2 u_sync_ack (.clk(clk), .rst(rst), .d(bus.net_tx_ack), .q(ack_s));
  ni_sync2 u_sync_req (.clk(clk), .rst(rst), .d(bus.net_rx_req), .q(req_s));

  tx_state_t        tx_state;
  logic             tx_req;
  logic             tx_err;
  logic [WIDTH-1:0] tx_pkt;
  logic             tx_accept;
  logic             dest_bad;

  assign tx_accept = bus.pe_tx_valid && (tx_state == T_IDLE);
  assign dest_bad  = int'(bus.pe_tx_dest) >= ROWS * COLS;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= T_IDLE;
      tx_req   <= 1'b0;
      tx_err   <= 1'b0;
      tx_pkt   <= '0;
    end else begin
      tx_err <= 1'b0;
      case (tx_state)
        T_IDLE: begin
          if (tx_accept) begin
            if (dest_bad) begin
              tx_err <= 1'b1;
            end else begin
              tx_pkt   <= {bus.pe_tx_payload, build_header(NODE_NUM, int'(bus.pe_tx_dest), COLS)};
              tx_req   <= 1'b1;
              tx_state <= T_REQ;
            end
          end
        end
        T_REQ: begin
          if (ack_s) begin
            tx_req   <= 1'b0;
            tx_state <= T_REL;
          end
        end
        T_REL: begin
          if (!ack_s) tx_state <= T_IDLE;
        end
        default: begin
          tx_req   <= 1'b0;
          tx_state <= T_IDLE;
        end
      endcase
    end
  end

  assign bus.pe_tx_ready = (tx_state == T_IDLE);
  assign bus.pe_tx_err   = tx_err;
  assign bus.net_tx_req  = tx_req;
  assign bus.net_tx_data = tx_pkt;

  rx_state_t        rx_state;
  logic             rx_ack;
  logic             rx_full;
  logic [PL_W-1:0]  rx_pl;
  logic             rx_pop;
  logic             rx_cap;

  // A held-off request is captured in the same cycle the PE drains the buffer.
  assign rx_pop = rx_full && bus.pe_rx_ready;
  assign rx_cap = (rx_state == R_IDLE) && req_s && (!rx_full || rx_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state <= R_IDLE;
      rx_ack   <= 1'b0;
      rx_full  <= 1'b0;
      rx_pl    <= '0;
    end else begin
      if (rx_cap) begin
        rx_pl   <= bus.net_rx_data[WIDTH-1:Y_HOP_LOC+1];
        rx_full <= 1'b1;
      end else if (rx_pop) begin
        rx_full <= 1'b0;
      end
      case (rx_state)
        R_IDLE: begin
          if (rx_cap) begin
            rx_ack   <= 1'b1;
            rx_state <= R_ACK;
          end
        end
        R_ACK: begin
          if (!req_s) begin
            rx_ack   <= 1'b0;
            rx_state <= R_IDLE;
          end
        end
        default: begin
          rx_ack   <= 1'b0;
          rx_state <= R_IDLE;
        end
      endcase
    end
  end

  assign bus.net_rx_ack    = rx_ack;
  assign bus.pe_rx_valid   = rx_full;
  assign bus.pe_rx_payload = rx_pl;

`ifdef NI_HOP_CHECK_EN
  logic hop_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hop_err <= 1'b0;
    end else if (rx_cap && ((|bus.net_rx_data[X_HOP_LOC:1]) ||
                            (|bus.net_rx_data[Y_HOP_LOC:X_HOP_LOC+2]))) begin
      hop_err <= 1'b1;
    end
  end

  assign bus.pe_rx_hop_err = hop_err;
`else
  logic unused_rx_hdr;
  assign unused_rx_hdr     = ^bus.net_rx_data[Y_HOP_LOC:0];
  assign bus.pe_rx_hop_err = 1'b0;
`endif

endmodule
